// File: rtl/endec_job_scheduler_pkg.sv
// Shared definitions for the endec job scheduler: default sizing,
// scheduler state encoding, mode_sel values and requester indices.
package endec_job_scheduler_pkg;

    localparam int FRAME_BITS_DEF = 192;
    localparam int CODE_W_DEF     = 2;
    localparam int K_MAX_DEF      = 9;
    localparam int TIMEOUT_DEF    = 1023;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ENC_RUN = 3'd2,
        DEC_RUN = 3'd3,
        RESP    = 3'd4
    } sched_state_t;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    // Bit positions of the two requesters in request/grant vectors.
    localparam int REQ_ENC = 0;
    localparam int REQ_DEC = 1;

endpackage

// File: rtl/endec_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   enable     grants are only issued while high
//   req[1:0]   requests (bit REQ_ENC = encode, bit REQ_DEC = decode)
//   update     a grant was taken this cycle; advance the priority pointer
//   grant[1:0] one-hot (or zero) combinational grant
// After reset the decode requester wins a tie.
module endec_job_scheduler_rr_arbiter2
    import endec_job_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic favour_dec;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = favour_dec ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // The requester just served drops to lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            favour_dec <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            favour_dec <= grant[REQ_ENC];
        end
    end

endmodule

// File: rtl/endec_job_scheduler.sv
// Job-level front end for the endec convolutional encoder / Viterbi core.
// Takes encode and decode jobs from two requesters (round-robin), latches
// configuration and data, clears the core, runs it, collects its output and
// returns it on the requester's response channel, with a stall watchdog.
// Ports:
//   sys_clk, rst                      clock, asynchronous active-high reset
//   i_enc_* / o_enc_*                 encode job request and response
//   i_dec_* / o_dec_*                 decode job request and response
//   o_rsp_err                         current response ended by timeout
//   i_code_rate/i_constr_len/i_gen_poly  config, sampled at accept
//   o_endec_clr/o_en/o_mode_sel/o_code_rate/o_constr_len/o_gen_poly  core control
//   o_encoder_bit, o_decoder_frame    core data inputs
//   i_encoder_data/done, i_decoder_data/done  core outputs
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrating, ready offered to one valid requester
// CLEAR   | one-cycle core clear, config already driven from latches
// ENC_RUN | core enabled, serial info bits out, symbols collected
// DEC_RUN | core enabled, latched frame out, waiting for decode done
// RESP    | response valid on the granted channel until ready
module endec_job_scheduler
    import endec_job_scheduler_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int CODE_W     = CODE_W_DEF,
    parameter int K_MAX      = K_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       i_enc_valid,
    output logic                       o_enc_ready,
    input  logic [FRAME_BITS-1:0]      i_enc_data,
    output logic                       o_enc_rsp_valid,
    input  logic                       i_enc_rsp_ready,
    output logic [FRAME_BITS*CODE_W-1:0] o_enc_result,
    input  logic                       i_dec_valid,
    output logic                       o_dec_ready,
    input  logic [2*FRAME_BITS-1:0]    i_dec_frame,
    output logic                       o_dec_rsp_valid,
    input  logic                       i_dec_rsp_ready,
    output logic [FRAME_BITS-1:0]      o_dec_result,
    output logic                       o_rsp_err,
    input  logic                       i_code_rate,
    input  logic [1:0]                 i_constr_len,
    input  logic [CODE_W*K_MAX-1:0]    i_gen_poly,
    output logic                       o_endec_clr,
    output logic                       o_en,
    output logic                       o_mode_sel,
    output logic                       o_code_rate,
    output logic [1:0]                 o_constr_len,
    output logic [CODE_W*K_MAX-1:0]    o_gen_poly,
    output logic                       o_encoder_bit,
    output logic [2*FRAME_BITS-1:0]    o_decoder_frame,
    input  logic [CODE_W-1:0]          i_encoder_data,
    input  logic                       i_encoder_done,
    input  logic [FRAME_BITS-1:0]      i_decoder_data,
    input  logic                       i_decoder_done
);

    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam int SC_W = $clog2(FRAME_BITS);
    localparam int RI_W = $clog2(FRAME_BITS * CODE_W);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [BC_W-1:0] BIT_END  = BC_W'(FRAME_BITS);
    localparam logic [SC_W-1:0] SYM_LAST = SC_W'(FRAME_BITS - 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);

    sched_state_t state, next_state;

    logic [1:0]                   req;
    logic [1:0]                   grant;
    logic                         accept;

    logic                         mode;
    logic                         code_rate_q;
    logic [1:0]                   constr_len_q;
    logic [CODE_W*K_MAX-1:0]      gen_poly_q;
    logic [FRAME_BITS-1:0]        enc_data_q;
    logic [2*FRAME_BITS-1:0]      dec_frame_q;
    logic [FRAME_BITS*CODE_W-1:0] enc_res;
    logic [FRAME_BITS-1:0]        dec_res;
    logic                         err;
    logic [BC_W-1:0]              bit_cnt;
    logic [SC_W-1:0]              sym_cnt;
    logic [WD_W-1:0]              wd_cnt;
    logic [RI_W-1:0]              sym_base;

    assign req[REQ_ENC] = i_enc_valid;
    assign req[REQ_DEC] = i_dec_valid;
    assign accept       = (state == IDLE) && (grant != 2'b00);

    endec_job_scheduler_rr_arbiter2 u_arb (
        .clk    (sys_clk),
        .rst    (rst),
        .enable (state == IDLE),
        .req    (req),
        .update (accept),
        .grant  (grant)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = CLEAR;
            end
            CLEAR: begin
                next_state = (mode == MODE_ENC) ? ENC_RUN : DEC_RUN;
            end
            ENC_RUN: begin
                if (i_encoder_done && (sym_cnt == SYM_LAST)) begin
                    next_state = RESP;
                end else if (!i_encoder_done && (wd_cnt == WD_MAX)) begin
                    next_state = RESP;
                end
            end
            DEC_RUN: begin
                if (i_decoder_done || (wd_cnt == WD_MAX)) next_state = RESP;
            end
            RESP: begin
                if (((mode == MODE_ENC) && i_enc_rsp_ready) ||
                    ((mode == MODE_DEC) && i_dec_rsp_ready)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign sym_base = RI_W'(sym_cnt) * RI_W'(CODE_W);

    // A done strobe always takes precedence over the watchdog: capture and
    // clear wd_cnt; err is only set when the watchdog fires without one.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mode         <= MODE_DEC;
            code_rate_q  <= 1'b0;
            constr_len_q <= '0;
            gen_poly_q   <= '0;
            enc_data_q   <= '0;
            dec_frame_q  <= '0;
            enc_res      <= '0;
            dec_res      <= '0;
            err          <= 1'b0;
            bit_cnt      <= '0;
            sym_cnt      <= '0;
            wd_cnt       <= '0;
        end else begin
            if (accept) begin
                mode         <= grant[REQ_ENC] ? MODE_ENC : MODE_DEC;
                code_rate_q  <= i_code_rate;
                constr_len_q <= i_constr_len;
                gen_poly_q   <= i_gen_poly;
                if (grant[REQ_ENC]) begin
                    enc_data_q <= i_enc_data;
                end else begin
                    dec_frame_q <= i_dec_frame;
                end
                enc_res <= '0;
                dec_res <= '0;
                err     <= 1'b0;
            end
            case (state)
                CLEAR: begin
                    bit_cnt <= '0;
                    sym_cnt <= '0;
                    wd_cnt  <= '0;
                end
                ENC_RUN: begin
                    if (bit_cnt != BIT_END) bit_cnt <= bit_cnt + 1'b1;
                    if (i_encoder_done) begin
                        enc_res[sym_base +: CODE_W] <= i_encoder_data;
                        sym_cnt <= sym_cnt + 1'b1;
                        wd_cnt  <= '0;
                    end else if (wd_cnt == WD_MAX) begin
                        err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DEC_RUN: begin
                    if (i_decoder_done) begin
                        dec_res <= i_decoder_data;
                        wd_cnt  <= '0;
                    end else if (wd_cnt == WD_MAX) begin
                        err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_enc_ready     = grant[REQ_ENC];
    assign o_dec_ready     = grant[REQ_DEC];
    assign o_endec_clr     = (state == CLEAR);
    assign o_en            = (state == ENC_RUN) || (state == DEC_RUN);
    assign o_mode_sel      = mode;
    assign o_code_rate     = code_rate_q;
    assign o_constr_len    = constr_len_q;
    assign o_gen_poly      = gen_poly_q;
    // Past the last info bit the core is fed zeros to flush its tail.
    assign o_encoder_bit   = (state == ENC_RUN) && (bit_cnt != BIT_END) && enc_data_q[bit_cnt];
    assign o_decoder_frame = dec_frame_q;
    assign o_enc_rsp_valid = (state == RESP) && (mode == MODE_ENC);
    assign o_dec_rsp_valid = (state == RESP) && (mode == MODE_DEC);
    assign o_enc_result    = enc_res;
    assign o_dec_result    = dec_res;
    assign o_rsp_err       = (state == RESP) && err;

endmodule

// File: tb/tb_endec_job_scheduler.sv
module tb_endec_job_scheduler;

    localparam int FB = 192;
    localparam int CW = 2;
    localparam int KM = 9;

    logic               sys_clk;
    logic               rst;
    logic               i_enc_valid, i_dec_valid;
    logic               i_enc_rsp_ready, i_dec_rsp_ready;
    logic [FB-1:0]      i_enc_data;
    logic [2*FB-1:0]    i_dec_frame;
    logic               i_code_rate;
    logic [1:0]         i_constr_len;
    logic [CW*KM-1:0]   i_gen_poly;
    logic [CW-1:0]      i_encoder_data;
    logic               i_encoder_done;
    logic [FB-1:0]      i_decoder_data;
    logic               i_decoder_done;

    logic               o_enc_ready, o_dec_ready, o_enc_rsp_valid, o_dec_rsp_valid;
    logic [FB*CW-1:0]   o_enc_result;
    logic [FB-1:0]      o_dec_result;
    logic               o_rsp_err, o_endec_clr, o_en, o_mode_sel, o_code_rate, o_encoder_bit;
    logic [1:0]         o_constr_len;
    logic [CW*KM-1:0]   o_gen_poly;
    logic [2*FB-1:0]    o_decoder_frame;

    // Second instance with a short watchdog, used only for the timeout case.
    logic               t_dec_valid, t_enc_valid, t_dec_rsp_ready, t_enc_rsp_ready;
    logic               t_encoder_done, t_decoder_done;
    logic               t_enc_ready, t_dec_ready, t_enc_rsp_valid, t_dec_rsp_valid;
    logic [FB*CW-1:0]   t_enc_result;
    logic [FB-1:0]      t_dec_result;
    logic               t_rsp_err, t_endec_clr, t_en, t_mode_sel, t_code_rate, t_encoder_bit;
    logic [1:0]         t_constr_len;
    logic [CW*KM-1:0]   t_gen_poly;
    logic [2*FB-1:0]    t_decoder_frame;

    int n_total = 0;
    int n_bad   = 0;

    endec_job_scheduler dut (
        .sys_clk(sys_clk), .rst(rst),
        .i_enc_valid(i_enc_valid), .o_enc_ready(o_enc_ready), .i_enc_data(i_enc_data),
        .o_enc_rsp_valid(o_enc_rsp_valid), .i_enc_rsp_ready(i_enc_rsp_ready), .o_enc_result(o_enc_result),
        .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready), .i_dec_frame(i_dec_frame),
        .o_dec_rsp_valid(o_dec_rsp_valid), .i_dec_rsp_ready(i_dec_rsp_ready), .o_dec_result(o_dec_result),
        .o_rsp_err(o_rsp_err), .i_code_rate(i_code_rate), .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly),
        .o_endec_clr(o_endec_clr), .o_en(o_en), .o_mode_sel(o_mode_sel), .o_code_rate(o_code_rate),
        .o_constr_len(o_constr_len), .o_gen_poly(o_gen_poly), .o_encoder_bit(o_encoder_bit),
        .o_decoder_frame(o_decoder_frame), .i_encoder_data(i_encoder_data), .i_encoder_done(i_encoder_done),
        .i_decoder_data(i_decoder_data), .i_decoder_done(i_decoder_done)
    );

    endec_job_scheduler #(.TIMEOUT(16)) dut_t (
        .sys_clk(sys_clk), .rst(rst),
        .i_enc_valid(t_enc_valid), .o_enc_ready(t_enc_ready), .i_enc_data(i_enc_data),
        .o_enc_rsp_valid(t_enc_rsp_valid), .i_enc_rsp_ready(t_enc_rsp_ready), .o_enc_result(t_enc_result),
        .i_dec_valid(t_dec_valid), .o_dec_ready(t_dec_ready), .i_dec_frame(i_dec_frame),
        .o_dec_rsp_valid(t_dec_rsp_valid), .i_dec_rsp_ready(t_dec_rsp_ready), .o_dec_result(t_dec_result),
        .o_rsp_err(t_rsp_err), .i_code_rate(i_code_rate), .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly),
        .o_endec_clr(t_endec_clr), .o_en(t_en), .o_mode_sel(t_mode_sel), .o_code_rate(t_code_rate),
        .o_constr_len(t_constr_len), .o_gen_poly(t_gen_poly), .o_encoder_bit(t_encoder_bit),
        .o_decoder_frame(t_decoder_frame), .i_encoder_data(i_encoder_data), .i_encoder_done(t_encoder_done),
        .i_decoder_data(i_decoder_data), .i_decoder_done(t_decoder_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_val(input string tag, input logic [2*FB-1:0] got, input logic [2*FB-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    logic [FB*CW-1:0] ones_res;
    logic [2*FB-1:0]  frame_a5;
    logic [FB-1:0]    dead_val;
    int               n;
    bit               exp_enc;

    initial begin
        ones_res = '1;
        frame_a5 = {48{8'hA5}};
        dead_val = {12{16'hDEAD}};
        rst = 1'b1;
        i_enc_valid = 0; i_dec_valid = 0; i_enc_rsp_ready = 0; i_dec_rsp_ready = 0;
        i_enc_data = '0; i_dec_frame = '0; i_code_rate = 0; i_constr_len = '0; i_gen_poly = '0;
        i_encoder_data = '0; i_encoder_done = 0; i_decoder_data = '0; i_decoder_done = 0;
        t_enc_valid = 0; t_dec_valid = 0; t_enc_rsp_ready = 0; t_dec_rsp_ready = 0;
        t_encoder_done = 0; t_decoder_done = 0;

        // Reset values
        repeat (2) tick;
        check_val("rst_en", o_en, 0);
        check_val("rst_clr", o_endec_clr, 0);
        check_val("rst_mode", o_mode_sel, 0);
        check_val("rst_poly", o_gen_poly, 0);
        check_val("rst_enc_res", o_enc_result, 0);
        check_val("rst_rsp_err", o_rsp_err, 0);
        rst = 1'b0;
        tick;

        // Tie after reset goes to decode; nothing is taken (no clock edge).
        i_enc_valid = 1; i_dec_valid = 1; #1;
        check_val("tie_dec_ready", o_dec_ready, 1);
        check_val("tie_enc_ready", o_enc_ready, 0);
        i_enc_valid = 0; i_dec_valid = 0; #1;

        // Encode job: data 1, done from cycle 3 for 192 cycles, symbols 2'b11
        i_enc_data = 192'h1; i_code_rate = 1; i_constr_len = 2'b10; i_gen_poly = 18'h35A5;
        i_enc_valid = 1; #1;
        check_val("enc_ready", o_enc_ready, 1);
        check_val("enc_dec_ready", o_dec_ready, 0);
        tick;
        i_enc_valid = 0; i_gen_poly = 18'h00F0; i_code_rate = 0; i_constr_len = 2'b00; #1;
        check_val("enc_clr", o_endec_clr, 1);
        check_val("enc_clr_en", o_en, 0);
        check_val("enc_mode", o_mode_sel, 1);
        check_val("enc_rate", o_code_rate, 1);
        check_val("enc_klen", o_constr_len, 2'b10);
        check_val("enc_poly", o_gen_poly, 18'h35A5);
        tick;
        check_val("enc_clr_off", o_endec_clr, 0);
        check_val("enc_en_c0", o_en, 1);
        check_val("enc_bit0", o_encoder_bit, 1);
        tick;
        check_val("enc_bit1", o_encoder_bit, 0);
        tick;
        tick;
        for (int i = 0; i < FB; i++) begin
            i_encoder_done = 1; i_encoder_data = 2'b11;
            check_val("enc_en_run", o_en, 1);
            tick;
        end
        i_encoder_done = 0; i_encoder_data = 2'b00; #1;
        check_val("enc_rsp_valid", o_enc_rsp_valid, 1);
        check_val("enc_dec_rsp_valid", o_dec_rsp_valid, 0);
        check_val("enc_en_resp", o_en, 0);
        check_val("enc_err", o_rsp_err, 0);
        check_val("enc_result", o_enc_result, ones_res);
        check_val("enc_poly_held", o_gen_poly, 18'h35A5);
        // Back-pressure: response held while ready is low
        for (int i = 0; i < 10; i++) begin
            tick;
            check_val("bp_valid", o_enc_rsp_valid, 1);
            check_val("bp_result", o_enc_result, ones_res);
        end
        i_enc_rsp_ready = 1;
        tick;
        i_enc_rsp_ready = 0; #1;
        check_val("enc_rsp_drop", o_enc_rsp_valid, 0);
        check_val("enc_err_drop", o_rsp_err, 0);

        // Both valid for 4 jobs: encode was served last, so dec, enc, dec, enc
        i_enc_data = 192'h0; i_dec_frame = 384'h55;
        i_enc_valid = 1; i_dec_valid = 1;
        for (int j = 0; j < 4; j++) begin
            exp_enc = (j % 2) == 1;
            #1;
            check_val("rr_enc_ready", o_enc_ready, exp_enc);
            check_val("rr_dec_ready", o_dec_ready, !exp_enc);
            check_val("rr_one_ready", o_enc_ready & o_dec_ready, 0);
            tick;
            check_val("rr_mode", o_mode_sel, exp_enc);
            tick;
            if (exp_enc) begin
                for (int i = 0; i < FB; i++) begin
                    i_encoder_done = 1; i_encoder_data = 2'b01;
                    tick;
                end
                i_encoder_done = 0;
            end else begin
                i_decoder_done = 1; i_decoder_data = 192'(j + 7);
                tick;
                i_decoder_done = 0;
            end
            #1;
            check_val("rr_rsp_valid", exp_enc ? o_enc_rsp_valid : o_dec_rsp_valid, 1);
            check_val("rr_resp_no_ready", o_enc_ready | o_dec_ready, 0);
            i_enc_rsp_ready = 1; i_dec_rsp_ready = 1;
            tick;
            i_enc_rsp_ready = 0; i_dec_rsp_ready = 0;
        end
        i_enc_valid = 0; i_dec_valid = 0; #1;

        // Decode job: A5 frame, done after 200 cycles with DEAD pattern
        i_dec_frame = frame_a5; i_dec_valid = 1; #1;
        check_val("dec_ready", o_dec_ready, 1);
        tick;
        i_dec_valid = 0; #1;
        check_val("dec_clr", o_endec_clr, 1);
        check_val("dec_mode", o_mode_sel, 0);
        check_val("dec_clr_en", o_en, 0);
        tick;
        check_val("dec_clr_pulse", o_endec_clr, 0);
        check_val("dec_en", o_en, 1);
        check_val("dec_frame", o_decoder_frame, frame_a5);
        repeat (200) tick;
        i_decoder_done = 1; i_decoder_data = dead_val;
        tick;
        i_decoder_done = 0; i_decoder_data = 192'h1234; #1;
        check_val("dec_rsp_valid", o_dec_rsp_valid, 1);
        check_val("dec_enc_rsp_valid", o_enc_rsp_valid, 0);
        check_val("dec_result", o_dec_result, dead_val);
        check_val("dec_err", o_rsp_err, 0);
        // Done strobe outside a RUN state is ignored
        i_decoder_done = 1;
        tick;
        i_decoder_done = 0; #1;
        check_val("dec_stray_done", o_dec_result, dead_val);
        i_dec_rsp_ready = 1;
        tick;
        i_dec_rsp_ready = 0; #1;
        check_val("dec_rsp_drop", o_dec_rsp_valid, 0);

        // Timeout on the short-watchdog instance (TIMEOUT=16)
        t_dec_valid = 1; #1;
        check_val("to_ready", t_dec_ready, 1);
        tick;
        t_dec_valid = 0;
        tick;
        check_val("to_en", t_en, 1);
        n = 0;
        while (!t_dec_rsp_valid && n < 100) begin
            tick;
            n++;
        end
        check_val("to_latency", n, 17);
        check_val("to_err", t_rsp_err, 1);
        check_val("to_result", t_dec_result, 0);
        check_val("to_en_off", t_en, 0);
        t_dec_rsp_ready = 1;
        tick;
        t_dec_rsp_ready = 0; #1;
        check_val("to_err_drop", t_rsp_err, 0);

        // Reset in the middle of an encode run
        i_enc_data = {48{4'hA}}; i_gen_poly = 18'h1FF; i_code_rate = 1; i_enc_valid = 1; #1;
        tick;
        i_enc_valid = 0;
        tick;
        check_val("mid_en", o_en, 1);
        for (int i = 0; i < 5; i++) begin
            i_encoder_done = 1; i_encoder_data = 2'b01;
            tick;
        end
        i_encoder_done = 0;
        #2;
        rst = 1; #1;
        check_val("mid_rst_en", o_en, 0);
        check_val("mid_rst_mode", o_mode_sel, 0);
        check_val("mid_rst_poly", o_gen_poly, 0);
        check_val("mid_rst_rate", o_code_rate, 0);
        check_val("mid_rst_res", o_enc_result, 0);
        check_val("mid_rst_frame", o_decoder_frame, 0);
        tick;
        rst = 0;
        tick;
        check_val("mid_no_rsp", o_enc_rsp_valid, 0);
        // Following decode job completes normally
        i_dec_frame = 384'h1234; i_dec_valid = 1; #1;
        check_val("post_ready", o_dec_ready, 1);
        tick;
        i_dec_valid = 0;
        tick;
        repeat (3) tick;
        i_decoder_done = 1; i_decoder_data = 192'hBEEF;
        tick;
        i_decoder_done = 0; #1;
        check_val("post_valid", o_dec_rsp_valid, 1);
        check_val("post_result", o_dec_result, 192'hBEEF);
        check_val("post_err", o_rsp_err, 0);
        i_dec_rsp_ready = 1;
        tick;
        i_dec_rsp_ready = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/endec_job_scheduler.md
Name: endec_job_scheduler

Overview:
- Job-level front end for the endec convolutional encoder/Viterbi decoder core.
- Accepts encode jobs and decode jobs from two independent requesters and arbitrates between them round-robin.
- Latches per-job configuration, clears the core, then drives en/mode_sel and the data inputs.
- Collects the core's output, returns it on a per-requester response channel, and flags a timeout if the core stalls.

Parameters:
FRAME_BITS, 192, information bits per job (decoder output width)
CODE_W, 2, symbol bits per info bit (MAX_CODE_RATE)
K_MAX, 9, generator polynomial width (MAX_CONSTRAINT_LENGTH)
TIMEOUT, 1023, max cycles without progress before a job aborts with error

Ports:
sys_clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_enc_valid  in  1  encode job request
o_enc_ready  out  1  encode job accepted when valid&ready
i_enc_data  in  FRAME_BITS  info bits; bit 0 is encoded first
o_enc_rsp_valid  out  1  encode result valid; held until ready
i_enc_rsp_ready  in  1  encode result consumed
o_enc_result  out  FRAME_BITS*CODE_W  symbol k at bits [k*CODE_W +: CODE_W]
i_dec_valid  in  1  decode job request
o_dec_ready  out  1  decode job accepted when valid&ready
i_dec_frame  in  2*FRAME_BITS  received frame
o_dec_rsp_valid  out  1  decode result valid; held until ready
i_dec_rsp_ready  in  1  decode result consumed
o_dec_result  out  FRAME_BITS  decoded bits
o_rsp_err  out  1  current response ended by timeout
i_code_rate  in  1  config, sampled at accept
i_constr_len  in  2  config, sampled at accept
i_gen_poly  in  CODE_W*K_MAX  flattened polynomials, poly j at [j*K_MAX +: K_MAX]; sampled at accept
o_endec_clr  out  1  one-cycle core clear
o_en  out  1  core enable
o_mode_sel  out  1  1 = encode, 0 = decode
o_code_rate, o_constr_len, o_gen_poly  out  1/2/CODE_W*K_MAX  latched config
o_encoder_bit  out  1  serial info bit to core
o_decoder_frame  out  2*FRAME_BITS  latched frame to core
i_encoder_data  in  CODE_W  core encoder symbol
i_encoder_done  in  1  symbol valid strobe
i_decoder_data  in  FRAME_BITS  core decoder output
i_decoder_done  in  1  decode complete strobe

Behaviour:
- Reset: state IDLE; every output 0; round-robin pointer favours decode. Reset mid-job drops the job with no response.
- FSM states: IDLE, CLEAR, ENC_RUN, DEC_RUN, RESP.
- IDLE, arbitration:
  - ready is combinational and is asserted only in IDLE, to exactly one requester.
  - If only one requester is valid, that one is granted.
  - If both are valid, the requester not served last is granted.
  - On accept: latch config and data, update the pointer, go to CLEAR.
- CLEAR (1 cycle): o_endec_clr=1, o_en=0, config outputs and o_mode_sel already driven from latches. Next state is ENC_RUN or DEC_RUN.
- ENC_RUN:
  - o_en=1.
  - o_encoder_bit = i_enc_data[bit_cnt]; bit_cnt increments every cycle. Once bit_cnt reaches FRAME_BITS, drive 0 (tail flush) and saturate.
  - Each cycle with i_encoder_done=1: store i_encoder_data at index sym_cnt, then increment sym_cnt.
  - When the store lands at sym_cnt == FRAME_BITS-1, go to RESP with err=0.
- DEC_RUN:
  - o_en=1; o_decoder_frame holds the latched frame.
  - On i_decoder_done, capture i_decoder_data and go to RESP with err=0.
- Timeout:
  - wd_cnt clears on entry to a RUN state and on any done strobe, and increments otherwise.
  - When wd_cnt reaches TIMEOUT, go to RESP with err=1 and the partial result (uncaptured bits 0).
  - A done strobe in the same cycle as timeout wins: the capture happens and wd_cnt clears.
- RESP:
  - o_en=0; the rsp_valid of the granted channel is 1, with the result and o_rsp_err stable.
  - On rsp_ready, go to IDLE; o_rsp_err clears with valid.
  - New requests are not accepted during RESP.
- Done strobes outside a RUN state are ignored. Config input changes after accept have no effect.
- Latency: accept → o_endec_clr is 1 cycle; o_en rises 2 cycles after accept. RUN done/timeout → rsp_valid is 1 cycle.

Decomposition:
- The shared package (alongside param_def) holds:
  - sched_state_t enum;
  - MODE_ENC/MODE_DEC constants;
  - FRAME_BITS and TIMEOUT defaults.
- One sub-module, rr_arbiter2: a 2-way round-robin arbiter with a grant-update input. Counters and the FSM stay in the top.

Test Plan:
- Encode job, i_enc_data=192'h1, core model asserting done from cycle 3 for 192 cycles with symbol 2'b11 → o_enc_result all 1s, o_rsp_err=0, o_en high only in ENC_RUN.
- Decode job, frame 384'hA5.., done after 200 cycles with data 192'hDEAD.. → o_dec_result=192'hDEAD.., o_mode_sel=0, clr pulse exactly 1 cycle.
- Both valid continuously for 4 jobs → grants dec, enc, dec, enc; never both ready in one cycle.
- Decode with no done, TIMEOUT=16 → o_dec_rsp_valid 17 cycles after o_en rise, o_rsp_err=1, result 0.
- Response back-pressure: rsp_ready low for 10 cycles → valid and result held stable; config input changed during the job → o_gen_poly unchanged.
- rst asserted mid-ENC_RUN → all outputs 0 asynchronously; a next decode job completes normally.
